// File: rtl/mdu_execute_if.sv
// -----------------------------------------------------------------------------
// mdu_execute_if
//   Request/response bundle between the execute stage and the multiply/divide
//   unit.
//
//   Handshake rules (both channels): a transfer happens on a rising clock edge
//   where valid and ready are both high. A producer that raises valid keeps
//   valid and its payload unchanged until that transfer.
//
//   Request  : req_valid, req_ready, req_funct3, req_rs1, req_rs2, req_rd_addr
//   Response : resp_valid, resp_ready, resp_result, resp_rd_addr
//
//   master : the pipeline side that issues requests and takes results.
//   slave  : the multiply/divide unit.
// -----------------------------------------------------------------------------
interface mdu_execute_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [4:0]      req_rd_addr;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic [4:0]      resp_rd_addr;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_rd_addr, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_rd_addr
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_rd_addr, resp_ready,
    output req_ready, resp_valid, resp_result, resp_rd_addr
  );
endinterface

// File: rtl/mdu_execute.sv
// -----------------------------------------------------------------------------
// mdu_execute
//   Multi-cycle RV32M multiply/divide unit. Accepts one operation at a time,
//   iterates UNROLL bits per cycle (shift-add multiply, restoring divide on
//   magnitudes), then holds the signed-corrected result until it is taken.
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     flush       : kill any in-flight or pending operation
//     busy        : high whenever the unit is not IDLE
//     dbg_state   : current FSM state (0 IDLE, 1 CALC, 2 DONE)
//     bus         : mdu_execute_if slave modport (request + response channels)
//
//   Optional build macro MDU_RESULT_REUSE_EN: remembers the last completed
//   iterated divide; an identical DIV/REM (or DIVU/REMU) completes in 1 cycle.
// -----------------------------------------------------------------------------
module mdu_execute #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  output logic         busy,
  output logic [1:0]   dbg_state,
  mdu_execute_if.slave bus
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] hi_q, hi_d;      // mul: running upper product; div: remainder
  logic [XLEN-1:0] lo_q, lo_d;      // mul: multiplier/lower product; div: dividend/quotient
  logic [XLEN-1:0] opnd_q, opnd_d;  // mul: multiplicand magnitude; div: divisor magnitude
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;          // negate product / quotient
  logic            neg_rem_q, neg_rem_d;  // remainder follows the dividend sign
  logic [1:0]      sel_q, sel_d;          // funct3[1:0]: picks high half / remainder
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  // Request decode
  logic [2:0]      f3;
  logic            req_div, req_sgn, s1, s2, op1_neg, op2_neg;
  logic [XLEN-1:0] mag1, mag2, special_res;
  logic            special;

  // Iteration datapath
  logic [XLEN-1:0]   it_hi, it_lo;
  logic [XLEN:0]     step_w;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, quot_res, rem_res, div_res;

`ifdef MDU_RESULT_REUSE_EN
  logic            rv_valid_q, rv_valid_d;
  logic [XLEN-1:0] rv_rs1_q, rv_rs1_d, rv_rs2_q, rv_rs2_d;
  logic            rv_sgn_q, rv_sgn_d;
  logic [XLEN-1:0] rv_quot_q, rv_quot_d, rv_rem_q, rv_rem_d;
  logic            reuse_hit;
`endif

  always_comb begin
    f3      = bus.req_funct3;
    req_div = f3[2];
    req_sgn = ~f3[0];                     // DIV/REM signed, DIVU/REMU not
    s1      = (f3[1:0] != 2'd3);          // MUL, MULH, MULHSU treat rs1 as signed
    s2      = ~f3[1];                     // MUL, MULH treat rs2 as signed
    op1_neg = (req_div ? req_sgn : s1) & bus.req_rs1[XLEN-1];
    op2_neg = (req_div ? req_sgn : s2) & bus.req_rs2[XLEN-1];
    mag1    = op1_neg ? -bus.req_rs1 : bus.req_rs1;
    mag2    = op2_neg ? -bus.req_rs2 : bus.req_rs2;

    special     = 1'b0;
    special_res = '0;
    if (req_div && bus.req_rs2 == '0) begin
      special     = 1'b1;
      special_res = f3[1] ? bus.req_rs1 : '1;
    end else if (req_div && req_sgn && bus.req_rs1 == INT_MIN && bus.req_rs2 == '1) begin
      special     = 1'b1;
      special_res = f3[1] ? '0 : bus.req_rs1;
    end else if (!req_div && (bus.req_rs1 == '0 || bus.req_rs2 == '0)) begin
      special     = 1'b1;
      special_res = '0;
    end
  end

`ifdef MDU_RESULT_REUSE_EN
  assign reuse_hit = req_div && rv_valid_q && (bus.req_rs1 == rv_rs1_q) &&
                     (bus.req_rs2 == rv_rs2_q) && (req_sgn == rv_sgn_q);
`endif

  // UNROLL unrolled steps of either shift-add multiply or restoring divide.
  always_comb begin
    it_hi  = hi_q;
    it_lo  = lo_q;
    step_w = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div_q) begin
        step_w = {it_hi, it_lo[XLEN-1]};
        it_lo  = {it_lo[XLEN-2:0], 1'b0};
        if (step_w >= {1'b0, opnd_q}) begin
          step_w   = step_w - {1'b0, opnd_q};
          it_lo[0] = 1'b1;
        end
        it_hi = step_w[XLEN-1:0];
      end else begin
        step_w = {1'b0, it_hi} + (it_lo[0] ? {1'b0, opnd_q} : '0);
        it_lo  = {step_w[0], it_lo[XLEN-1:1]};
        it_hi  = step_w[XLEN:1];
      end
    end
    prod     = {it_hi, it_lo};
    prod_s   = neg_q ? -prod : prod;
    mul_res  = (sel_q == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    quot_res = neg_q ? -it_lo : it_lo;
    rem_res  = neg_rem_q ? -it_hi : it_hi;
    div_res  = sel_q[1] ? rem_res : quot_res;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    sel_d     = sel_q;
    result_d  = result_q;
    rd_d      = rd_q;
`ifdef MDU_RESULT_REUSE_EN
    rv_valid_d = flush ? 1'b0 : rv_valid_q;
    rv_rs1_d   = rv_rs1_q;
    rv_rs2_d   = rv_rs2_q;
    rv_sgn_d   = rv_sgn_q;
    rv_quot_d  = rv_quot_q;
    rv_rem_d   = rv_rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A flush in the accept cycle discards the request.
        if (bus.req_valid && !flush) begin
          rd_d = bus.req_rd_addr;
          if (special) begin
            result_d = special_res;
            state_d  = S_DONE;
`ifdef MDU_RESULT_REUSE_EN
          end else if (reuse_hit) begin
            result_d = f3[1] ? rv_rem_q : rv_quot_q;
            state_d  = S_DONE;
`endif
          end else begin
            hi_d      = '0;
            lo_d      = req_div ? mag1 : mag2;
            opnd_d    = req_div ? mag2 : mag1;
            is_div_d  = req_div;
            neg_d     = op1_neg ^ op2_neg;
            neg_rem_d = op1_neg;
            sel_d     = f3[1:0];
            count_d   = CW'(STEPS);
            state_d   = S_CALC;
`ifdef MDU_RESULT_REUSE_EN
            // Candidate entry; becomes valid only if this divide completes.
            if (req_div) begin
              rv_valid_d = 1'b0;
              rv_rs1_d   = bus.req_rs1;
              rv_rs2_d   = bus.req_rs2;
              rv_sgn_d   = req_sgn;
            end
`endif
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = it_hi;
          lo_d    = it_lo;
          count_d = count_q - 1'b1;
          if (count_q == CW'(1)) begin
            result_d = is_div_q ? div_res : mul_res;
            state_d  = S_DONE;
`ifdef MDU_RESULT_REUSE_EN
            if (is_div_q) begin
              rv_valid_d = 1'b1;
              rv_quot_d  = quot_res;
              rv_rem_d   = rem_res;
            end
`endif
          end
        end
      end
      S_DONE: begin
        // Flush wins over resp_ready: the result is dropped either way.
        if (flush || bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
`ifdef MDU_RESULT_REUSE_EN
      rv_valid_q <= 1'b0;
      rv_rs1_q   <= '0;
      rv_rs2_q   <= '0;
      rv_sgn_q   <= 1'b0;
      rv_quot_q  <= '0;
      rv_rem_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
`ifdef MDU_RESULT_REUSE_EN
      rv_valid_q <= rv_valid_d;
      rv_rs1_q   <= rv_rs1_d;
      rv_rs2_q   <= rv_rs2_d;
      rv_sgn_q   <= rv_sgn_d;
      rv_quot_q  <= rv_quot_d;
      rv_rem_q   <= rv_rem_d;
`endif
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.resp_valid   = (state_q == S_DONE);
  assign bus.resp_result  = result_q;
  assign bus.resp_rd_addr = rd_q;
  assign busy             = (state_q != S_IDLE);
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_mdu_execute.sv
// -----------------------------------------------------------------------------
// tb_mdu_execute
//   Directed bench for mdu_execute (XLEN=32, UNROLL=1). Expected values are
//   hand-computed RV32M results; latency counts the edge that first shows
//   resp_valid, starting at 1 for the edge right after acceptance.
// -----------------------------------------------------------------------------
module tb_mdu_execute;
  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  logic [1:0] dbg_state;

  mdu_execute_if #(.XLEN(XLEN)) bus ();

  mdu_execute #(.XLEN(XLEN), .UNROLL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .busy      (busy),
    .dbg_state (dbg_state),
    .bus       (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [XLEN-1:0] exp_q[$];

`ifdef MDU_RESULT_REUSE_EN
  localparam int REUSE_LAT = 1;
`else
  localparam int REUSE_LAT = 33;
`endif

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] rd);
    bus.req_valid   = 1'b1;
    bus.req_funct3  = f3;
    bus.req_rs1     = a;
    bus.req_rs2     = b;
    bus.req_rd_addr = rd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; leaves time #1 after the edge showing resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [4:0] rd,
                        output logic [XLEN-1:0] res, output logic [4:0] rd_o,
                        output int lat);
    issue(f3, a, b, rd);
    wait_resp(lat);
    res  = bus.resp_result;
    rd_o = bus.resp_rd_addr;
    take_resp();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_rs1 = '0;
    bus.req_rs2 = '0; bus.req_rd_addr = '0; bus.resp_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    tests_run++; if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
    tests_run++; if (bus.resp_result !== 32'h0) begin tests_failed++; $display("FAIL reset_result got %h exp 0", bus.resp_result); end
    tests_run++; if (bus.resp_rd_addr !== 5'd0) begin tests_failed++; $display("FAIL reset_rd got %0d exp 0", bus.resp_rd_addr); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    logic [XLEN-1:0] r; logic [4:0] rd; int lat;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, r, rd, lat);
    tests_run++; if (r !== 32'hFFFFFFEB) begin tests_failed++; $display("FAIL mul_7_m3 got %h exp ffffffeb", r); end
    tests_run++; if (rd !== 5'd5) begin tests_failed++; $display("FAIL mul_rd got %0d exp 5", rd); end
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL mul_latency got %0d exp 33", lat); end
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, r, rd, lat);
    tests_run++; if (r !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL mulhu_max got %h exp fffffffe", r); end
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd7, r, rd, lat);
    tests_run++; if (r !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mulhsu_m1_2 got %h exp ffffffff", r); end
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd8, r, rd, lat);
    tests_run++; if (r !== 32'h40000000) begin tests_failed++; $display("FAIL mulh_min_min got %h exp 40000000", r); end
    run_op(3'd0, 32'd0, 32'd1234, 5'd9, r, rd, lat);
    tests_run++; if (r !== 32'h0) begin tests_failed++; $display("FAIL mul_zero got %h exp 0", r); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL mul_zero_latency got %0d exp 1", lat); end
  endtask

  task automatic test_div();
    logic [XLEN-1:0] r; logic [4:0] rd; int lat;
    run_op(3'd4, 32'hFFFFFFEC, 32'd3, 5'd10, r, rd, lat);
    tests_run++; if (r !== 32'hFFFFFFFA) begin tests_failed++; $display("FAIL div_m20_3 got %h exp fffffffa", r); end
    run_op(3'd6, 32'hFFFFFFEC, 32'd3, 5'd11, r, rd, lat);
    tests_run++; if (r !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL rem_m20_3 got %h exp fffffffe", r); end
    run_op(3'd5, 32'd20, 32'd0, 5'd12, r, rd, lat);
    tests_run++; if (r !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL divu_by0 got %h exp ffffffff", r); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL divu_by0_latency got %0d exp 1", lat); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, r, rd, lat);
    tests_run++; if (r !== 32'h0) begin tests_failed++; $display("FAIL rem_ovf got %h exp 0", r); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL rem_ovf_latency got %0d exp 1", lat); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, r, rd, lat);
    tests_run++; if (r !== 32'h80000000) begin tests_failed++; $display("FAIL div_ovf got %h exp 80000000", r); end
    run_op(3'd7, 32'd20, 32'd0, 5'd15, r, rd, lat);
    tests_run++; if (r !== 32'd20) begin tests_failed++; $display("FAIL remu_by0 got %h exp 14", r); end
    run_op(3'd7, 32'hFFFFFFFF, 32'd10, 5'd16, r, rd, lat);
    tests_run++; if (r !== 32'd5) begin tests_failed++; $display("FAIL remu_max_10 got %h exp 5", r); end
    run_op(3'd5, 32'd1000, 32'd7, 5'd17, r, rd, lat);
    tests_run++; if (r !== 32'd142) begin tests_failed++; $display("FAIL divu_1000_7 got %h exp 8e", r); end
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL divu_latency got %0d exp 33", lat); end
  endtask

  task automatic test_vectors();
    logic [2:0]      f3_t [6];
    logic [XLEN-1:0] a_t  [6];
    logic [XLEN-1:0] b_t  [6];
    logic [XLEN-1:0] r, e; logic [4:0] rd; int lat;
    f3_t[0] = 3'd1; a_t[0] = 32'hFFFFFFF9; b_t[0] = 32'd3;        exp_q.push_back(32'hFFFFFFFF);
    f3_t[1] = 3'd3; a_t[1] = 32'h80000000; b_t[1] = 32'd4;        exp_q.push_back(32'h00000002);
    f3_t[2] = 3'd5; a_t[2] = 32'd7;        b_t[2] = 32'd100;      exp_q.push_back(32'h00000000);
    f3_t[3] = 3'd6; a_t[3] = 32'd7;        b_t[3] = 32'hFFFFFFFD; exp_q.push_back(32'h00000001);
    f3_t[4] = 3'd4; a_t[4] = 32'd7;        b_t[4] = 32'hFFFFFFFD; exp_q.push_back(32'hFFFFFFFE);
    f3_t[5] = 3'd0; a_t[5] = 32'h00010000; b_t[5] = 32'h00010000; exp_q.push_back(32'h00000000);
    for (int i = 0; i < 6; i++) begin
      run_op(f3_t[i], a_t[i], b_t[i], 5'(i + 1), r, rd, lat);
      e = exp_q.pop_front();
      tests_run++; if (r !== e) begin tests_failed++; $display("FAIL vector_%0d got %h exp %h", i, r, e); end
    end
  endtask

  task automatic test_rd_zero();
    logic [XLEN-1:0] r; logic [4:0] rd; int lat;
    run_op(3'd0, 32'd6, 32'd7, 5'd0, r, rd, lat);
    tests_run++; if (r !== 32'd42) begin tests_failed++; $display("FAIL rd0_result got %h exp 2a", r); end
    tests_run++; if (rd !== 5'd0) begin tests_failed++; $display("FAIL rd0_addr got %0d exp 0", rd); end
  endtask

  task automatic test_hold();
    int lat;
    issue(3'd0, 32'd9, 32'd9, 5'd3);
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++; if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd81 || bus.req_ready !== 1'b0 || bus.resp_rd_addr !== 5'd3) begin
        tests_failed++;
        $display("FAIL hold_cycle_%0d got v=%b r=%h rdy=%b rd=%0d exp v=1 r=51 rdy=0 rd=3",
                 i, bus.resp_valid, bus.resp_result, bus.req_ready, bus.resp_rd_addr);
      end
    end
    take_resp();
    tests_run++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release got v=%b rdy=%b busy=%b exp 0 1 0", bus.resp_valid, bus.req_ready, busy);
    end
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] r; logic [4:0] rd; int lat; int seen;
    issue(3'd0, 32'd123, 32'd456, 5'd20);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_calc got busy=%b rdy=%b v=%b exp 0 1 0", busy, bus.req_ready, bus.resp_valid);
    end
    run_op(3'd0, 32'd123, 32'd456, 5'd21, r, rd, lat);
    tests_run++; if (r !== 32'd56088) begin tests_failed++; $display("FAIL flush_next_result got %h exp db18", r); end
    tests_run++; if (rd !== 5'd21 || lat !== 33) begin tests_failed++; $display("FAIL flush_next_rd_lat got %0d/%0d exp 21/33", rd, lat); end
    // Flush in DONE with resp_ready high: flush wins, response dropped.
    issue(3'd5, 32'd5, 32'd0, 5'd22);
    flush = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; bus.resp_ready = 1'b0;
    tests_run++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL flush_done got v=%b busy=%b exp 0 0", bus.resp_valid, busy);
    end
    // Flush in the accept cycle: request discarded, no response within 40 cycles.
    bus.req_valid = 1'b1; bus.req_funct3 = 3'd4; bus.req_rs1 = 32'd50; bus.req_rs2 = 32'd0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid === 1'b1 || busy === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL flush_accept got %0d busy cycles exp 0", seen); end
  endtask

  task automatic test_async_reset();
    logic [XLEN-1:0] r; logic [4:0] rd; int lat;
    issue(3'd0, 32'd11, 32'd13, 5'd4);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_result !== 32'h0 || bus.resp_rd_addr !== 5'd0) begin
      tests_failed++;
      $display("FAIL async_reset got busy=%b v=%b r=%h rd=%0d exp 0 0 0 0", busy, bus.resp_valid, bus.resp_result, bus.resp_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd11, 32'd13, 5'd4, r, rd, lat);
    tests_run++; if (r !== 32'd143) begin tests_failed++; $display("FAIL after_reset_mul got %h exp 8f", r); end
  endtask

  task automatic test_reuse();
    logic [XLEN-1:0] r; logic [4:0] rd; int lat;
    run_op(3'd4, 32'd100, 32'd7, 5'd25, r, rd, lat);
    tests_run++; if (r !== 32'd14) begin tests_failed++; $display("FAIL reuse_div got %h exp e", r); end
    tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL reuse_div_latency got %0d exp 33", lat); end
    run_op(3'd6, 32'd100, 32'd7, 5'd26, r, rd, lat);
    tests_run++; if (r !== 32'd2) begin tests_failed++; $display("FAIL reuse_rem got %h exp 2", r); end
    tests_run++; if (lat !== REUSE_LAT) begin tests_failed++; $display("FAIL reuse_rem_latency got %0d exp %0d", lat, REUSE_LAT); end
    tests_run++; if (rd !== 5'd26) begin tests_failed++; $display("FAIL reuse_rem_rd got %0d exp 26", rd); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_vectors();
    test_rd_zero();
    test_hold();
    test_flush();
    test_async_reset();
    test_reuse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded 500000 time units");
    $fatal(1, "timeout");
  end
endmodule
